board_write_arbiter: RTL and testbench

BOARD_WRITE_ARBITER -- requirements
Module: board_write_arbiter

---
 rtl/board_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_board_write_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_write_arbiter.sv
// Round-robin arbiter serialising mover updates into the board RAM:
// blank the vacated block, draw the sprite at its destination, then acknowledge.
module board_write_arbiter #(
  parameter int unsigned N_REQ      = 5,
  parameter int unsigned BOARD_SIZE = 768,
  parameter logic [3:0]  BLANK_TILE = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*10-1:0]   old_loc,
  input  logic [N_REQ*10-1:0]   new_loc,
  input  logic [N_REQ*4-1:0]    tile,
  output logic                  wren,
  output logic [9:0]            write_addr,
  output logic [3:0]            write_data,
  output logic [N_REQ-1:0]      ack,
  output logic                  err,
  output logic                  busy,
  output logic                  collide
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0] BS = 11'(BOARD_SIZE);
  localparam logic [9:0]  NO_LOC = 10'h3FF;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, ACK} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     grant, grant_n;
  logic [PW-1:0]     pick, cand;
  logic              found;
  logic [9:0]        old_q, old_n;
  logic [9:0]        new_q, new_n;
  logic [3:0]        tile_q, tile_n;
  logic              bad_q, bad_n;
  logic              wren_n;
  logic [9:0]        addr_n;
  logic [3:0]        data_n;
  logic [N_REQ-1:0]  ack_n;
  logic              err_n;
  logic              coll_c;
  logic [9:0]        loc_tab [N_REQ];

  function automatic logic in_rng(input logic [9:0] a);
    return {1'b0, a} < BS;
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PW'((32'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Output registers are loaded from the next state, so each write appears
  // during the cycle its state is occupied.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    old_n   = old_q;
    new_n   = new_q;
    tile_n  = tile_q;
    bad_n   = bad_q;
    wren_n  = 1'b0;
    addr_n  = write_addr;
    data_n  = write_data;
    ack_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          old_n   = old_loc[32'(pick)*10 +: 10];
          new_n   = new_loc[32'(pick)*10 +: 10];
          tile_n  = tile[32'(pick)*4 +: 4];
          bad_n   = !in_rng(old_n) || !in_rng(new_n);
          ptr_n   = (32'(pick) == N_REQ - 1) ? '0 : PW'(32'(pick) + 1);
          if (old_n == new_n) begin
            state_n = DRAW;
            if (in_rng(new_n)) begin
              wren_n = 1'b1;
              addr_n = new_n;
              data_n = tile_n;
            end
          end else begin
            state_n = CLEAR;
            if (in_rng(old_n)) begin
              wren_n = 1'b1;
              addr_n = old_n;
              data_n = BLANK_TILE;
            end
          end
        end
      end
      CLEAR: begin
        state_n = DRAW;
        if (in_rng(new_q)) begin
          wren_n = 1'b1;
          addr_n = new_q;
          data_n = tile_q;
        end
      end
      DRAW: begin
        state_n      = ACK;
        ack_n[grant] = 1'b1;
        err_n        = bad_q;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    coll_c = 1'b0;
    for (int unsigned i = 1; i < N_REQ; i++)
      if (loc_tab[0] != NO_LOC && loc_tab[i] == loc_tab[0]) coll_c = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      old_q      <= '0;
      new_q      <= '0;
      tile_q     <= '0;
      bad_q      <= 1'b0;
      wren       <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      ack        <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      collide    <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) loc_tab[i] <= NO_LOC;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      grant      <= grant_n;
      old_q      <= old_n;
      new_q      <= new_n;
      tile_q     <= tile_n;
      bad_q      <= bad_n;
      wren       <= wren_n;
      write_addr <= addr_n;
      write_data <= data_n;
      ack        <= ack_n;
      err        <= err_n;
      busy       <= (state_n != IDLE);
      collide    <= coll_c;
      // Table changes on entry to ACK so collide follows the ack pulse by one cycle.
      if (state == DRAW && in_rng(new_q)) loc_tab[grant] <= new_q;
    end
  end

endmodule

// File: tb/tb_board_write_arbiter.sv
// Directed bench for board_write_arbiter: table of single moves plus
// round-robin and reset-abort sequences.
module tb_board_write_arbiter;

  localparam int unsigned N = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*10-1:0] old_loc;
  logic [N*10-1:0] new_loc;
  logic [N*4-1:0]  tile;
  logic            wren;
  logic [9:0]      write_addr;
  logic [3:0]      write_data;
  logic [N-1:0]    ack;
  logic            err;
  logic            busy;
  logic            collide;

  int total = 0;
  int bad   = 0;

  logic [9:0] last_a;
  logic [3:0] last_d;
  logic       prev_col;

  typedef struct {
    int unsigned idx;
    logic [9:0]  o;
    logic [9:0]  n;
    logic [3:0]  t;
    logic        same;
    logic        w1;
    logic        w2;
    logic        e;
    logic        col;
  } vec_t;

  vec_t vecs [10];

  board_write_arbiter #(
    .N_REQ      (N),
    .BOARD_SIZE (768),
    .BLANK_TILE (4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .old_loc    (old_loc),
    .new_loc    (new_loc),
    .tile       (tile),
    .wren       (wren),
    .write_addr (write_addr),
    .write_data (write_data),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .collide    (collide)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    last_a   = '0;
    last_d   = '0;
    prev_col = 1'b0;
  endtask

  task automatic do_move(input vec_t v);
    @(negedge clk);
    req = '0;
    req[v.idx] = 1'b1;
    old_loc[v.idx*10 +: 10] = v.o;
    new_loc[v.idx*10 +: 10] = v.n;
    tile[v.idx*4 +: 4]      = v.t;
    @(negedge clk);
    // Grant taken: drop the request and trash the inputs; the move must still finish.
    req     = '0;
    old_loc = '1;
    new_loc = '1;
    tile    = '1;
    if (!v.same) begin
      chk("clr_wren", 32'(wren), 32'(v.w1));
      if (v.w1) begin
        last_a = v.o;
        last_d = 4'b0000;
      end
      chk("clr_addr", 32'(write_addr), 32'(last_a));
      chk("clr_data", 32'(write_data), 32'(last_d));
      chk("clr_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("drw_wren", 32'(wren), 32'(v.w2));
    if (v.w2) begin
      last_a = v.n;
      last_d = v.t;
    end
    chk("drw_addr", 32'(write_addr), 32'(last_a));
    chk("drw_data", 32'(write_data), 32'(last_d));
    chk("drw_ack", 32'(ack), 32'd0);
    chk("drw_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ack_wren", 32'(wren), 32'd0);
    chk("ack_val", 32'(ack), 32'd1 << v.idx);
    chk("ack_err", 32'(err), 32'(v.e));
    chk("ack_busy", 32'(busy), 32'd1);
    chk("ack_col", 32'(collide), 32'(prev_col));
    @(negedge clk);
    chk("idl_ack", 32'(ack), 32'd0);
    chk("idl_err", 32'(err), 32'd0);
    chk("idl_busy", 32'(busy), 32'd0);
    chk("idl_wren", 32'(wren), 32'd0);
    chk("idl_col", 32'(collide), 32'(v.col));
    prev_col = v.col;
  endtask

  initial begin
    int k;
    int last_cyc;
    reset   = 1'b1;
    req     = '0;
    old_loc = '0;
    new_loc = '0;
    tile    = '0;

    //           idx  old      new      tile   same w1 w2 err col
    vecs[0] = '{0, 10'd33,  10'd34,  4'd3,  0, 1, 1, 0, 0};
    vecs[1] = '{2, 10'd100, 10'd100, 4'd5,  1, 0, 1, 0, 0};
    vecs[2] = '{1, 10'd50,  10'd800, 4'd7,  0, 1, 0, 1, 0};
    vecs[3] = '{4, 10'd900, 10'd10,  4'd9,  0, 0, 1, 1, 0};
    vecs[4] = '{0, 10'd34,  10'd200, 4'd3,  0, 1, 1, 0, 0};
    vecs[5] = '{3, 10'd5,   10'd200, 4'd6,  0, 1, 1, 0, 1};
    vecs[6] = '{0, 10'd200, 10'd201, 4'd3,  0, 1, 1, 0, 0};
    vecs[7] = '{1, 10'd767, 10'd767, 4'd15, 1, 0, 1, 0, 0};
    vecs[8] = '{2, 10'd768, 10'd768, 4'd8,  1, 0, 0, 1, 0};
    vecs[9] = '{0, 10'd201, 10'd10,  4'd2,  0, 1, 1, 0, 1};

    @(negedge clk);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_data", 32'(write_data), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_col", 32'(collide), 32'd0);
    do_reset();

    for (int i = 0; i < 10; i++) do_move(vecs[i]);

    // All movers request at once; each drops on its own ack.
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      old_loc[i*10 +: 10] = 10'(i*20 + 1);
      new_loc[i*10 +: 10] = 10'(i*20 + 2);
      tile[i*4 +: 4]      = 4'(i + 1);
    end
    req = '1;
    k = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && k < int'(N); cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("rr_order", 32'(ack), 32'd1 << k);
        if (k > 0) chk("rr_gap", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        req = req & ~ack;
        k++;
      end
    end
    chk("rr_done", 32'(k), 32'(N));

    // Reset in the middle of a move aborts it and clears the pointer.
    do_reset();
    @(negedge clk);
    req = 5'b00010;
    old_loc[10 +: 10] = 10'd300;
    new_loc[10 +: 10] = 10'd301;
    tile[4 +: 4]      = 4'd4;
    @(negedge clk);
    chk("ab_clr_wren", 32'(wren), 32'd1);
    @(negedge clk);
    chk("ab_drw_wren", 32'(wren), 32'd1);
    chk("ab_drw_addr", 32'(write_addr), 32'd301);
    #1 reset = 1'b1;
    #1;
    chk("ab_rst_wren", 32'(wren), 32'd0);
    chk("ab_rst_busy", 32'(busy), 32'd0);
    chk("ab_rst_addr", 32'(write_addr), 32'd0);
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk("ab_hold_ack", 32'(ack), 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ab_post_ack", 32'(ack), 32'd0);
      chk("ab_post_busy", 32'(busy), 32'd0);
    end
    old_loc[0 +: 10]  = 10'd400;
    new_loc[0 +: 10]  = 10'd401;
    old_loc[40 +: 10] = 10'd500;
    new_loc[40 +: 10] = 10'd501;
    req = 5'b10001;
    k = 0;
    for (int cyc = 0; cyc < 20 && k == 0; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("ab_ptr_grant", 32'(ack), 32'd1);
        k = 1;
      end
    end
    chk("ab_ack_seen", 32'(k), 32'd1);
    req = '0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
